// File: rtl/ifu.sv
// Multicycle instruction fetch stage: one AR/R read in flight, result handed to
// decode over valid/ready, next PC supplied by a commit redirect (which also flushes).
module ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    // AXI4-Lite-style read address channel
    output logic [63:0] araddr_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    // read data channel
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    // decode side
    output logic [31:0] inst_o,
    output logic [63:0] pc_o,
    output logic [1:0]  fault_o,
    output logic        d_valid_o,
    input  logic        d_ready_i,
    // commit redirect / flush
    input  logic        redirect_valid_i,
    input  logic [63:0] redirect_pc_i
);

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_ACCESS   = 2'b01;
    localparam logic [1:0] FAULT_MISALIGN = 2'b10;
    localparam logic [1:0] RESP_OKAY      = 2'b00;

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        RESP,
        HOLD,
        WAIT_NPC
    } state_t;

    state_t      state;
    logic [63:0] pc;
    logic [63:0] pending_pc;
    logic        discard;
    logic        misaligned;

    assign misaligned = (pc[1:0] != 2'b00);

    // Handshake outputs depend only on registers, never on inputs.
    assign araddr_o  = pc;
    assign arvalid_o = (state == REQ) && !misaligned;
    assign rready_o  = (state == RESP);
    assign d_valid_o = (state == HOLD);

    // NOTE: every register here, including pending_pc, gets a reset value so a
    // mid-transaction reset leaves no stale flush target or data behind.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            pending_pc <= RESET_PC;
            discard    <= 1'b0;
            inst_o     <= '0;
            pc_o       <= RESET_PC;
            fault_o    <= FAULT_NONE;
        end else begin
            case (state)
                BOOT: state <= REQ;

                REQ: begin
                    if (misaligned) begin
                        // Nothing is on the bus, so a redirect simply replaces the PC.
                        if (redirect_valid_i) begin
                            pc <= redirect_pc_i;
                        end else begin
                            inst_o  <= NOP_INST;
                            pc_o    <= pc;
                            fault_o <= FAULT_MISALIGN;
                            state   <= HOLD;
                        end
                    end else begin
                        // AR is never withdrawn: remember the target and drain later.
                        if (redirect_valid_i) begin
                            pending_pc <= redirect_pc_i;
                            discard    <= 1'b1;
                        end
                        if (arready_i) state <= RESP;
                    end
                end

                RESP: begin
                    if (rvalid_i) begin
                        if (discard || redirect_valid_i) begin
                            pc      <= redirect_valid_i ? redirect_pc_i : pending_pc;
                            discard <= 1'b0;
                            state   <= REQ;
                        end else begin
                            inst_o  <= (rresp_i == RESP_OKAY) ? rdata_i : NOP_INST;
                            fault_o <= (rresp_i == RESP_OKAY) ? FAULT_NONE : FAULT_ACCESS;
                            pc_o    <= pc;
                            state   <= HOLD;
                        end
                    end else if (redirect_valid_i) begin
                        pending_pc <= redirect_pc_i;
                        discard    <= 1'b1;
                    end
                end

                HOLD: begin
                    // A redirect wins over a simultaneous accept.
                    if (redirect_valid_i) begin
                        pc    <= redirect_pc_i;
                        state <= REQ;
                    end else if (d_ready_i) begin
                        state <= WAIT_NPC;
                    end
                end

                WAIT_NPC: begin
                    if (redirect_valid_i) begin
                        pc    <= redirect_pc_i;
                        state <= REQ;
                    end
                end

                default: state <= BOOT;
            endcase
        end
    end

endmodule
